slc3_mem_arbiter: RTL

Sequences and shares the SLC-3's single-port memory between the CPU datapath (MAR/MDR/Mem_OE/Mem_WE path) and a debug/program-loader port. Each transfer runs as a fixed-length memory access followed by a one-cycle acknowledge. The block sits between `datapath`/`ISDU` and the memory (`test_memory` in simulation, SRAM via `Mem2IO` on board). It replaces direct ISDU drive of the memory enables.

---
 rtl/slc3_mem_arbiter_if.sv | 27 ++
 rtl/slc3_mem_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/slc3_mem_arbiter_if.sv
// Bus bundle between the SLC-3 requesters (CPU datapath, debug loader) and the memory arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface slc3_mem_arbiter_if;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_oe, mem_we;
  logic        grant_dbg;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_oe, mem_we, grant_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_oe, mem_we, grant_dbg
  );
endinterface

// File: rtl/slc3_mem_arbiter.sv
// Shares the SLC-3 single-port memory between the CPU datapath and a debug/loader port.
// Round-robin arbitration; each transfer is WAIT_CYCLES of access followed by a one-cycle ack.
module slc3_mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  slc3_mem_arbiter_if.slave bus
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             last_dbg_q, own_dbg_q, we_q;
  logic [15:0]      addr_q, wdata_q;
  logic [1:0][15:0] rdata_q;   // [0] cpu, [1] dbg
  logic             grant, pick_dbg, last_cyc;

  // On a tie the port that was not served last wins.
  assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_dbg_q);
  assign grant    = (state_q == IDLE) & (bus.cpu_req | bus.dbg_req);
  assign last_cyc = (state_q == ACCESS) & (cnt_q == CNT_LAST);

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)    state_d = ACCESS;
      ACCESS:  if (last_cyc) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= '0;
      last_dbg_q <= 1'b1;
      own_dbg_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (grant) begin
        cnt_q     <= '0;
        own_dbg_q <= pick_dbg;
        we_q      <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
        addr_q    <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
        wdata_q   <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Read data is valid at the end of the last access cycle only.
      if (last_cyc && !we_q) rdata_q[own_dbg_q] <= bus.mem_rdata;
      if (state_q == DONE)   last_dbg_q <= own_dbg_q;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_oe    = (state_q == ACCESS) & ~we_q;
  assign bus.mem_we    = (state_q == ACCESS) &  we_q;
  assign bus.cpu_ack   = (state_q == DONE) & ~own_dbg_q;
  assign bus.dbg_ack   = (state_q == DONE) &  own_dbg_q;
  assign bus.grant_dbg = (state_q != IDLE) &  own_dbg_q;
  assign bus.cpu_rdata = rdata_q[0];
  assign bus.dbg_rdata = rdata_q[1];
endmodule
